// File: rtl/branch_predictor_gshare.sv
// Next-fetch-PC predictor: tagged BTB plus always-taken/bimodal/gshare direction.
// Optional return-address stack enabled by defining BP_RAS_EN.
module branch_predictor_gshare #(
  parameter int WORD_SIZE    = 16,
  parameter int BTB_IDX_SIZE = 6,
  parameter int PHT_IDX_SIZE = 8,
  parameter int GHR_LEN      = 6,
  parameter int MODE         = 2,
  parameter int RAS_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic                 fetch_fire,
  output logic                 btb_hit,
  output logic                 predict_taken,
  output logic [WORD_SIZE-1:0] predicted_pc,
  output logic [GHR_LEN-1:0]   pred_ghr,
  input  logic                 update_btb,
  input  logic [WORD_SIZE-1:0] update_pc,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic [1:0]           update_type,
  input  logic                 resolve_valid,
  input  logic [WORD_SIZE-1:0] resolve_pc,
  input  logic                 resolve_taken,
  input  logic [GHR_LEN-1:0]   resolve_ghr
);

  localparam int BTB_N = 1 << BTB_IDX_SIZE;
  localparam int PHT_N = 1 << PHT_IDX_SIZE;
  localparam int TAG_W = WORD_SIZE - BTB_IDX_SIZE;

  logic [BTB_N-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag    [BTB_N];
  logic [WORD_SIZE-1:0] r_target [BTB_N];
  logic [1:0]           r_type   [BTB_N];
  logic [1:0]           r_pht    [PHT_N];
  logic [GHR_LEN-1:0]   r_ghr;

  function automatic logic [PHT_IDX_SIZE-1:0] pht_idx(
    input logic [WORD_SIZE-1:0] a,
    input logic [GHR_LEN-1:0]   g
  );
    logic [PHT_IDX_SIZE-1:0] x;
    x = a[PHT_IDX_SIZE-1:0];
    if (MODE == 2) x = x ^ PHT_IDX_SIZE'(g);
    return x;
  endfunction

  logic [BTB_IDX_SIZE-1:0] w_idx;
  logic [BTB_IDX_SIZE-1:0] w_uidx;
  logic [PHT_IDX_SIZE-1:0] w_pidx;
  logic [PHT_IDX_SIZE-1:0] w_ridx;
  logic [WORD_SIZE-1:0]    w_npc;
  logic [1:0]              w_type;
  logic [1:0]              w_ctr;
  logic [1:0]              w_rctr;
  logic                    w_hit;
  logic                    w_dir;
  logic                    w_taken;
  logic                    w_pred_tk;
  logic [WORD_SIZE-1:0]    w_pred_pc;

  assign w_idx  = pc[BTB_IDX_SIZE-1:0];
  assign w_uidx = update_pc[BTB_IDX_SIZE-1:0];
  assign w_pidx = pht_idx(pc, r_ghr);
  assign w_ridx = pht_idx(resolve_pc, resolve_ghr);
  assign w_npc  = pc + WORD_SIZE'(1);
  assign w_type = r_type[w_idx];
  assign w_ctr  = r_pht[w_pidx];
  assign w_rctr = r_pht[w_ridx];
  assign w_hit  = r_valid[w_idx] &&
                  (r_tag[w_idx] == pc[WORD_SIZE-1:BTB_IDX_SIZE]);
  assign w_dir   = (MODE == 0) ? 1'b1 : w_ctr[1];
  assign w_taken = w_hit && ((w_type != 2'd0) || w_dir);

`ifdef BP_RAS_EN
  localparam int RAS_W = $clog2(RAS_DEPTH);

  logic [WORD_SIZE-1:0] r_ras [RAS_DEPTH];
  logic [RAS_W-1:0]     r_ras_ptr;
  logic [RAS_W:0]       r_ras_cnt;
  logic [RAS_W-1:0]     w_ptr_inc;
  logic                 w_ras_ne;
  logic                 w_push;
  logic                 w_pop;

  assign w_ptr_inc = r_ras_ptr + 1'b1;
  assign w_ras_ne  = (r_ras_cnt != '0);
  assign w_push    = fetch_fire && w_hit && (w_type == 2'd2);
  assign w_pop     = fetch_fire && w_hit && (w_type == 2'd3) && w_ras_ne;

  // Circular stack: a push when full silently overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (w_push) begin
      r_ras_ptr        <= w_ptr_inc;
      r_ras[w_ptr_inc] <= w_npc;
      if (r_ras_cnt != (RAS_W+1)'(RAS_DEPTH))
        r_ras_cnt <= r_ras_cnt + 1'b1;
    end else if (w_pop) begin
      r_ras_ptr <= r_ras_ptr - 1'b1;
      r_ras_cnt <= r_ras_cnt - 1'b1;
    end
  end
`else
  logic w_unused_ras;
  assign w_unused_ras = ^{fetch_fire, 32'(RAS_DEPTH)};
`endif

  always_comb begin
    w_pred_tk = 1'b0;
    w_pred_pc = w_npc;
    if (w_taken) begin
      w_pred_tk = 1'b1;
      w_pred_pc = r_target[w_idx];
    end
`ifdef BP_RAS_EN
    if (w_hit && (w_type == 2'd3)) begin
      w_pred_tk = w_ras_ne;
      w_pred_pc = w_ras_ne ? r_ras[r_ras_ptr] : w_npc;
    end
`endif
  end

  assign btb_hit       = w_hit;
  assign predict_taken = w_pred_tk;
  assign predicted_pc  = w_pred_pc;
  assign pred_ghr      = r_ghr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_ghr   <= '0;
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'b10;
    end else begin
      if (update_btb) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= update_pc[WORD_SIZE-1:BTB_IDX_SIZE];
        r_target[w_uidx] <= update_target;
        r_type[w_uidx]   <= update_type;
      end
      if (resolve_valid) begin
        if (resolve_taken && (w_rctr != 2'd3))
          r_pht[w_ridx] <= w_rctr + 2'd1;
        else if (!resolve_taken && (w_rctr != 2'd0))
          r_pht[w_ridx] <= w_rctr - 2'd1;
        r_ghr <= GHR_LEN'({r_ghr, resolve_taken});
      end
    end
  end

  logic w_unused_rpc;
  assign w_unused_rpc = ^resolve_pc[WORD_SIZE-1:PHT_IDX_SIZE];

endmodule
